mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the data-memory interface in the multi-cycle CPU.
//  Accepts one load/store request (byte/half/word) from the control FSM and
//  drives a byte-wide data memory one byte per cycle.
//  Loads are assembled with zero or sign extension.
//  Unaligned addresses are legal; multi-byte accesses are big-endian
//  (byte at addr = MSB).
// PARAMETERS
//  ADDR_W  8  memory byte-address width; mem_addr = low ADDR_W bits of (addr+i)
// PORTS
//  CLK        in   1       clock, all state updates on rising edge
//  RST_n      in   1       asynchronous, active-low reset
//  start      in   1       request strobe; sampled only in IDLE
//  is_store   in   1       1 = store, 0 = load; sampled with start
//  width      in   2       00 byte, 01 half, 11 word, 10 illegal; sampled with start
//  load_sign  in   1       1 = sign-extend load, 0 = zero-extend; sampled with start
//  addr       in   32      byte address; sampled with start
//  wdata      in   32      store data, right-justified; sampled with start
//  busy       out  1       high from the cycle after start until done (inclusive)
//  done       out  1       one-cycle completion pulse
//  err        out  1       valid with done; 1 = illegal width, no memory access
//  rdata      out  32      extended load result; valid from done until next accepted start
//  mem_addr   out  ADDR_W  byte address to memory
//  mem_we     out  1       byte write enable; memory writes on rising CLK
//  mem_wdata  out  8       byte to write
//  mem_rdata  in   8       combinational read data for mem_addr
// BEHAVIOUR
//  - Reset (async, RST_n=0): state IDLE; busy, done, err, mem_we = 0;
//    rdata, mem_addr, mem_wdata = 0. mem_we drops immediately, including mid-transfer.
//  - FSM: IDLE -> XFER on start with legal width; IDLE -> DONE on start with width 10.
//    XFER stays N cycles (N = 1/2/4), then -> DONE. DONE -> IDLE unconditionally.
//  - XFER beat i (0..N-1):
//    - mem_addr = addr+i, truncated to ADDR_W; wraps from 2^ADDR_W-1 to 0.
//    - Store: mem_we=1, mem_wdata = wdata byte (N-1-i), MSB first.
//    - Load: mem_we=0; mem_rdata shifted into an assembly register at the edge ending the beat.
//  - DONE: done=1 for exactly one cycle.
//    - Load: rdata = assembled N bytes, zero/sign-extended from bit 8N-1.
//    - Store: rdata unchanged.
//    - Illegal width: err=1, rdata unchanged, no mem_we ever asserted.
//  - err clears in IDLE. Latency from start edge to done = N+1 cycles (illegal width: 1).
//  - start while busy is ignored (no queueing). Request fields are registered at
//    acceptance; later input changes have no effect.
//  - Outside XFER: mem_we=0; mem_addr/mem_wdata hold their last value.
// STRUCTURE
//  - Shared package mem_access_pkg:
//    - width codes W_BYTE=2'b00, W_HALF=2'b01, W_WORD=2'b11
//    - state codes S_IDLE, S_XFER, S_DONE
//    - function beats(width) -> 1/2/4
//  - Sub-module ldst_extend (combinational): raw[31:0], width, sign -> 32-bit
//    extended value; reused by any later load path.
//  - Top: FSM, 2-bit beat counter, request registers, assembly shift register.
// TESTING
//  1. Store byte: addr=0x13, wdata=0xA1, width 00 -> 1 beat, mem_addr=0x13,
//     mem_wdata=0xA1, mem_we=1; done 2 cycles after start.
//  2. Load byte after (1): addr=0x13, sign=0 -> rdata=0x000000A1;
//     sign=1 -> rdata=0xFFFFFFA1.
//  3. Store half at 0x11: wdata=0xA1A1 -> bytes 0xA1@0x11, 0xA1@0x12.
//     Signed load half -> rdata=0xFFFFA1A1, done 3 cycles after start.
//  4. Unaligned word: store 0x00A1A1A1 @0x12, then load -> rdata=0x00A1A1A1.
//     Separately, word at 0xFE (ADDR_W=8) -> mem_addr 0xFE, 0xFF, 0x00, 0x01.
//  5. Illegal width 10 -> done+err next cycle, mem_we never 1, rdata unchanged.
//     start during busy -> ignored.
//  6. Deassert RST_n mid word-store (beat 2) -> mem_we=0 immediately, busy=0,
//     FSM IDLE; next start completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access path: request width codes,
// FSM state codes and the beat-count helper.
package mem_access_pkg;

  localparam logic [1:0] W_BYTE    = 2'b00;
  localparam logic [1:0] W_HALF    = 2'b01;
  localparam logic [1:0] W_ILLEGAL = 2'b10;
  localparam logic [1:0] W_WORD    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_XFER = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Number of byte beats needed for a width code; illegal width maps to 1
  // but never reaches the transfer state.
  function automatic logic [2:0] beats(input logic [1:0] w);
    logic [2:0] n;
    unique case (w)
      W_BYTE:  n = 3'd1;
      W_HALF:  n = 3'd2;
      W_WORD:  n = 3'd4;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ldst_extend.sv
// Load-data extender: takes a right-justified raw load value and widens it
// to 32 bits with zero or sign extension according to the access width.
module ldst_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  width,
  input  logic        sign,
  output logic [31:0] ext
);

  logic signBit;

  // Pick the top bit of the accessed field and replicate it when signed.
  always_comb begin
    signBit = 1'b0;
    ext     = raw;
    unique case (width)
      W_BYTE: begin
        signBit = sign & raw[7];
        ext     = {{24{signBit}}, raw[7:0]};
      end
      W_HALF: begin
        signBit = sign & raw[15];
        ext     = {{16{signBit}}, raw[15:0]};
      end
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the byte-wide data-memory interface. One load/store
// request (byte/half/word, big-endian, unaligned allowed) is carried out
// one byte per cycle; loads are assembled and extended into rdata.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        width,
  input  logic              load_sign,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_t      state;
  logic [1:0]  beatCnt;
  logic        reqStore;
  logic [1:0]  reqWidth;
  logic        reqSign;
  logic [31:0] storeShift;
  logic [23:0] asmReg;
  logic [31:0] asmNext;
  logic [31:0] extValue;
  logic [31:0] alignedWdata;
  logic [1:0]  lastBeat;
  logic        unusedAddrBits;

  // Only the low ADDR_W address bits reach the memory.
  assign unusedAddrBits = ^addr;

  assign asmNext  = {asmReg, mem_rdata};
  assign lastBeat = 2'(beats(reqWidth) - 3'd1);

  ldst_extend uExtend (
    .raw   (asmNext),
    .width (reqWidth),
    .sign  (reqSign),
    .ext   (extValue)
  );

  // Left-align store data so the most significant accessed byte goes out first.
  always_comb begin
    alignedWdata = wdata;
    unique case (width)
      W_BYTE:  alignedWdata = {wdata[7:0], 24'h0};
      W_HALF:  alignedWdata = {wdata[15:0], 16'h0};
      default: alignedWdata = wdata;
    endcase
  end

  // Request FSM with registered memory-side and completion outputs.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= S_IDLE;
      beatCnt    <= 2'd0;
      reqStore   <= 1'b0;
      reqWidth   <= W_BYTE;
      reqSign    <= 1'b0;
      storeShift <= 32'h0;
      asmReg     <= 24'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rdata      <= 32'h0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= 8'h0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            reqStore <= is_store;
            reqWidth <= width;
            reqSign  <= load_sign;
            beatCnt  <= 2'd0;
            asmReg   <= 24'h0;
            busy     <= 1'b1;
            if (width == W_ILLEGAL) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state      <= S_XFER;
              mem_addr   <= addr[ADDR_W-1:0];
              mem_we     <= is_store;
              mem_wdata  <= alignedWdata[31:24];
              storeShift <= alignedWdata << 8;
            end
          end
        end
        S_XFER: begin
          asmReg <= asmNext[23:0];
          if (beatCnt == lastBeat) begin
            state  <= S_DONE;
            done   <= 1'b1;
            mem_we <= 1'b0;
            if (!reqStore) rdata <= extValue;
          end else begin
            beatCnt    <= beatCnt + 2'd1;
            mem_addr   <= mem_addr + ADDR_W'(1);
            mem_wdata  <= storeShift[31:24];
            storeShift <= storeShift << 8;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte memory model, request-level expectation
// queue checked every cycle, and literal spot checks of known results.
module tb_mem_access_unit;

  localparam int ADDR_W = 8;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  width = 2'b00;
  logic        load_sign = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, err, mem_we;
  logic [31:0] rdata;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;

  logic [7:0] memArr [256] = '{default: 8'h00};
  logic [7:0] modelMem [256] = '{default: 8'h00};

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        busy;
    logic        done;
    logic        err;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [31:0] rdata;
    bit          chkWdata;
    bit          chkRdata;
  } exp_t;

  exp_t expQ[$];
  logic [7:0]  lastAddr = 8'h0;
  logic [7:0]  lastWdata = 8'h0;
  logic [31:0] lastRdata = 32'h0;
  bit          wdataKnown = 1'b1;

  logic [7:0] wrapAddr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  logic [7:0] wrapData [4] = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .start     (start),
    .is_store  (is_store),
    .width     (width),
    .load_sign (load_sign),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 CLK = ~CLK;

  assign mem_rdata = memArr[mem_addr];

  always @(posedge CLK) if (mem_we) memArr[mem_addr] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Drive one request for one cycle and queue what each following cycle must show.
  task automatic issue(input bit st, input logic [1:0] w, input bit sg,
                       input logic [31:0] a, input logic [31:0] d);
    int n;
    exp_t e;
    logic [31:0] val;
    logic [63:0] mask;
    logic [7:0] ba;
    is_store = st; width = w; load_sign = sg; addr = a; wdata = d; start = 1'b1;
    n = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : (w == 2'b11) ? 4 : 0;
    e.err = 1'b0; e.rdata = 32'h0; e.chkRdata = 1'b0;
    if (n == 0) begin
      e.busy = 1'b1; e.done = 1'b1; e.err = 1'b1; e.we = 1'b0;
      e.addr = lastAddr; e.wdata = lastWdata; e.chkWdata = wdataKnown;
      e.rdata = lastRdata; e.chkRdata = 1'b1;
      expQ.push_back(e);
    end else begin
      val = 32'h0;
      for (int i = 0; i < n; i++) begin
        ba = 8'(a + 32'(i));
        e.busy = 1'b1; e.done = 1'b0; e.err = 1'b0; e.we = st;
        e.addr = ba; e.wdata = 8'(d >> (8 * (n - 1 - i)));
        e.chkWdata = st; e.chkRdata = 1'b0;
        expQ.push_back(e);
        val = (val << 8) | 32'(modelMem[ba]);
        if (st) modelMem[ba] = e.wdata;
      end
      if (!st) begin
        mask = (64'h1 << (8 * n)) - 64'h1;
        if (sg && val[8 * n - 1]) val = val | ~mask[31:0];
        lastRdata = val;
        wdataKnown = 1'b0;
      end else begin
        lastWdata = 8'(d);
        wdataKnown = 1'b1;
      end
      lastAddr = 8'(a + 32'(n - 1));
      e.busy = 1'b1; e.done = 1'b1; e.err = 1'b0; e.we = 1'b0;
      e.addr = lastAddr; e.wdata = lastWdata; e.chkWdata = wdataKnown;
      e.rdata = lastRdata; e.chkRdata = 1'b1;
      expQ.push_back(e);
    end
    @(negedge CLK); #1;
    start = 1'b0; is_store = ~st; width = ~w; load_sign = ~sg;
    addr = $urandom; wdata = $urandom;
  endtask

  task automatic waitIdle();
    int guard = 0;
    while (expQ.size() > 0 && guard < 20) begin
      @(negedge CLK); #1;
      guard++;
    end
    if (expQ.size() > 0) begin
      checks++; failures++;
      $display("FAIL idle_timeout pending=%0d required=0", expQ.size());
      expQ.delete();
    end
    @(negedge CLK); #1;
  endtask

  // Per-cycle comparison against the queued request expectations or the idle state.
  initial begin : compare
    exp_t e;
    forever begin
      @(negedge CLK);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
      end else begin
        e.busy = 1'b0; e.done = 1'b0; e.err = 1'b0; e.we = 1'b0;
        e.addr = lastAddr; e.wdata = lastWdata; e.chkWdata = wdataKnown;
        e.rdata = lastRdata; e.chkRdata = 1'b1;
      end
      chk("cyc_busy", 32'(busy), 32'(e.busy));
      chk("cyc_done", 32'(done), 32'(e.done));
      chk("cyc_err", 32'(err), 32'(e.err));
      chk("cyc_we", 32'(mem_we), 32'(e.we));
      chk("cyc_addr", 32'(mem_addr), 32'(e.addr));
      if (e.chkWdata) chk("cyc_wdata", 32'(mem_wdata), 32'(e.wdata));
      if (e.chkRdata) chk("cyc_rdata", rdata, e.rdata);
    end
  end

  initial begin : stimulus
    logic [7:0] save42, save43;
    #2 RST_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", 32'(mem_wdata), 32'h0);
    @(negedge CLK); @(negedge CLK); #1;
    RST_n = 1'b1;
    @(negedge CLK); #1;

    // Store byte, single beat, done two cycles after start
    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'hA1);
    chk("sb_we", 32'(mem_we), 32'h1);
    chk("sb_addr", 32'(mem_addr), 32'h13);
    chk("sb_wdata", 32'(mem_wdata), 32'hA1);
    chk("sb_done_c1", 32'(done), 32'h0);
    @(negedge CLK); #1;
    chk("sb_done_c2", 32'(done), 32'h1);
    waitIdle();

    // Load byte back, zero and sign extended
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    waitIdle();
    chk("lb_zero", rdata, 32'h000000A1);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    waitIdle();
    chk("lb_sign", rdata, 32'hFFFFFFA1);

    // Half store at 0x11 (upper wdata bits ignored), signed half load
    issue(1'b1, 2'b01, 1'b0, 32'h11, 32'hDEADA1A1);
    waitIdle();
    issue(1'b0, 2'b01, 1'b1, 32'h11, 32'h0);
    chk("lh_done_c1", 32'(done), 32'h0);
    @(negedge CLK); #1;
    chk("lh_done_c2", 32'(done), 32'h0);
    @(negedge CLK); #1;
    chk("lh_done_c3", 32'(done), 32'h1);
    chk("lh_sign", rdata, 32'hFFFFA1A1);
    waitIdle();

    // Unaligned word store and load
    issue(1'b1, 2'b11, 1'b0, 32'h12, 32'h00A1A1A1);
    waitIdle();
    issue(1'b0, 2'b11, 1'b1, 32'h12, 32'h0);
    waitIdle();
    chk("lw_unal", rdata, 32'h00A1A1A1);

    // Word at the top of the address space wraps to 0
    issue(1'b1, 2'b11, 1'b0, 32'h1234_56FE, 32'hCAFEBABE);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_addr", 32'(mem_addr), 32'(wrapAddr[i]));
      chk("wrap_data", 32'(mem_wdata), 32'(wrapData[i]));
      if (i < 3) begin
        @(negedge CLK); #1;
      end
    end
    waitIdle();
    issue(1'b0, 2'b01, 1'b1, 32'hFF, 32'h0);
    waitIdle();
    chk("lh_wrap", rdata, 32'hFFFFFEBA);

    // Word load with a second start while busy that must be ignored
    issue(1'b0, 2'b11, 1'b0, 32'hFE, 32'h0);
    start = 1'b1; is_store = 1'b1; width = 2'b10; addr = 32'h0; wdata = 32'h0;
    @(negedge CLK); #1;
    start = 1'b0;
    waitIdle();
    chk("lw_wrap", rdata, 32'hCAFEBABE);

    // Illegal width: immediate done+err, no memory access, rdata kept
    issue(1'b1, 2'b10, 1'b0, 32'h30, 32'hFFFFFFFF);
    chk("ill_done", 32'(done), 32'h1);
    chk("ill_err", 32'(err), 32'h1);
    chk("ill_we", 32'(mem_we), 32'h0);
    chk("ill_rdata", rdata, 32'hCAFEBABE);
    waitIdle();
    chk("ill_err_clr", 32'(err), 32'h0);

    // Reset during beat 2 of a word store
    save42 = modelMem[8'h42];
    save43 = modelMem[8'h43];
    issue(1'b1, 2'b11, 1'b0, 32'h40, 32'h11223344);
    @(negedge CLK);
    @(negedge CLK);
    #2 RST_n = 1'b0;
    #1;
    chk("mid_we", 32'(mem_we), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_addr", 32'(mem_addr), 32'h0);
    expQ.delete();
    modelMem[8'h42] = save42;
    modelMem[8'h43] = save43;
    lastAddr = 8'h0; lastWdata = 8'h0; lastRdata = 32'h0; wdataKnown = 1'b1;
    @(negedge CLK); #1;
    RST_n = 1'b1;
    @(negedge CLK); #1;
    issue(1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
    waitIdle();
    chk("post_rst_lw", rdata, 32'h11220000);
    issue(1'b0, 2'b00, 1'b1, 32'h41, 32'h0);
    waitIdle();
    chk("post_rst_lb", rdata, 32'h00000022);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
